alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU.
- WIDTH-bit operands with a valid/ready handshake on both input and output sides.
- Full flag set: carry, zero, negative, overflow.
- Adds a multi-cycle iterative multiply and a signed compare; sits between the operand fetch stage and the writeback/result bus.

Parameters:
- WIDTH, 8, operand and result width in bits (minimum 4).
- OPW, 4, opcode width in bits (fixed at 4; exposed for the package only).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/opcode bundle valid.
- in_ready  output  1  block can accept a bundle this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- ALU_Sel  input  OPW  operation select.
- out_valid  output  1  result bundle valid.
- out_ready  input  1  downstream accepts the result.
- ALU_Out  output  WIDTH  result.
- CarryOut  output  1  carry/borrow/shifted-out bit.
- Zero  output  1  ALU_Out == 0.
- Negative  output  1  ALU_Out[WIDTH-1].
- Overflow  output  1  signed overflow (add/sub only, else 0).

Behaviour:
- Reset (async, rst=1): out_valid=0, ALU_Out=0, all flags=0, FSM returns to IDLE. Any in-flight multiply is discarded, with no output.
- Handshake:
  - Input transfers when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - While out_valid && !out_ready, ALU_Out and all flags hold stable.
- Opcodes; unlisted codes behave as ADD:
  - 0000 ADD: {C,R} = A+B.
  - 0001 SUB: R = A-B; C = borrow (A<B, unsigned).
  - 0010 SHL: R = A<<1; C = A[W-1].
  - 0011 SHR: R = A>>1; C = A[0].
  - 0100 ROL; 0101 ROR: C = the bit rotated across.
  - 0110 AND; 0111 OR; 1000 XOR: C = 0.
  - 1001 GTU: R = (A>B unsigned) ? 1 : 0.
  - 1010 EQ: R = (A==B) ? 1 : 0.
  - 1011 GTS: R = (A>B signed) ? 1 : 0.
  - 1100 MUL: R = low WIDTH bits of A*B (unsigned); C = 1 if the high half is nonzero.
  - 1101 ASR: R = arithmetic shift right by 1; C = A[0].
- Flags:
  - Overflow for ADD is set when the operand signs are equal and the result sign differs.
  - Overflow for SUB is set when the operand signs differ and the result sign differs from A's sign.
  - Zero and Negative are derived from the registered R for every op.
- Latency:
  - Single-cycle ops: result is registered; out_valid rises the cycle after the input transfer. Back-to-back throughput is 1 per cycle when out_ready=1.
  - MUL: shift-add, one partial product per cycle. out_valid rises exactly WIDTH+1 cycles after acceptance. in_ready=0 throughout.
- FSM states:
  - IDLE: on accept of a non-MUL op, register the result. On MUL, load the multiplicand, multiplier and a 2*WIDTH accumulator; set cnt=0; go to MUL.
  - MUL: add when multiplier LSB=1, shift, cnt++. When cnt==WIDTH-1, go to DONE.
  - DONE: load the output register if !out_valid || out_ready, then go to IDLE; otherwise stall in DONE.
- Boundaries:
  - MUL with a 0 operand still takes the full WIDTH+1 cycles.
  - ADD of all-ones + 1 wraps to 0 with C=1, Z=1.
  - Simultaneous output drain and input accept in the same cycle is legal; the new result replaces the old without a bubble.
  - ALU_Sel, A and B are sampled only on transfer; changes while in_ready=0 are ignored.

Decomposition:
- alu_pkg holds the opcode localparams (OP_ADD…OP_ASR) and the opcode width.
- Sub-module alu_mul_seq holds the iterative multiplier datapath plus its counter, with start/busy/done and a 2*WIDTH product.
- Top level holds the combinational op mux, flag logic, FSM and output register.

Test Plan:
- WIDTH=8, ADD A=8'hFF B=8'h01, out_ready=1 -> next cycle out_valid=1, ALU_Out=8'h00, C=1, Z=1, V=0.
- ADD A=8'h7F B=8'h01 -> ALU_Out=8'h80, N=1, V=1, C=0; SUB A=8'h03 B=8'h05 -> 8'hFE, C=1, N=1.
- MUL A=8'd20 B=8'd13 -> out_valid exactly 9 cycles after accept, ALU_Out=8'h04, C=1 (260). in_ready=0 during the MUL and DONE states.
- GTS A=8'hFF B=8'h01 -> ALU_Out=0; GTU on the same operands -> 1; ASR A=8'h81 -> 8'hC0, C=1.
- Backpressure: hold out_ready=0 for 5 cycles after an AND result -> outputs stable, in_ready=0. Release -> next queued XOR result on the following cycle.
- Assert rst mid-MUL (cycle 4) -> out_valid=0 and flags=0 immediately. After release, in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding and pipeline state type for the registered ALU.
package alu_pkg;

  localparam int ALU_OPW = 4;

  localparam logic [ALU_OPW-1:0] OP_ADD = 4'b0000;
  localparam logic [ALU_OPW-1:0] OP_SUB = 4'b0001;
  localparam logic [ALU_OPW-1:0] OP_SHL = 4'b0010;
  localparam logic [ALU_OPW-1:0] OP_SHR = 4'b0011;
  localparam logic [ALU_OPW-1:0] OP_ROL = 4'b0100;
  localparam logic [ALU_OPW-1:0] OP_ROR = 4'b0101;
  localparam logic [ALU_OPW-1:0] OP_AND = 4'b0110;
  localparam logic [ALU_OPW-1:0] OP_OR  = 4'b0111;
  localparam logic [ALU_OPW-1:0] OP_XOR = 4'b1000;
  localparam logic [ALU_OPW-1:0] OP_GTU = 4'b1001;
  localparam logic [ALU_OPW-1:0] OP_EQ  = 4'b1010;
  localparam logic [ALU_OPW-1:0] OP_GTS = 4'b1011;
  localparam logic [ALU_OPW-1:0] OP_MUL = 4'b1100;
  localparam logic [ALU_OPW-1:0] OP_ASR = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH steps.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;

  // done_o flags the cycle in which the final partial product is being added.
  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == CNT_LAST);
  assign product_o = acc_q;

  // Multiplier datapath and step counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_ONE;
      if (cnt_q == CNT_LAST) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes, full flag set and an
// iterative multiply handled by alu_mul_seq.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = ALU_OPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OPW-1:0]   ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Negative,
  output logic             Overflow
);

  alu_state_e         state_q;
  logic [WIDTH-1:0]   res_q;
  logic               carry_q, zero_q, neg_q, ovf_q, out_valid_q;

  logic [WIDTH:0]     sum_s, diff_s;
  logic               ovf_add_s, ovf_sub_s;
  logic [WIDTH-1:0]   res_d;
  logic               carry_d, ovf_d;
  logic               accept_s, drain_s, is_mul_s;
  logic               mul_busy_s, mul_done_s;
  logic [2*WIDTH-1:0] mul_prod_s;

  assign in_ready = (state_q == ST_IDLE) && !mul_busy_s && (!out_valid_q || out_ready);
  assign accept_s = in_valid && in_ready;
  assign drain_s  = out_valid_q && out_ready;
  assign is_mul_s = (ALU_Sel == OP_MUL);

  assign out_valid = out_valid_q;
  assign ALU_Out   = res_q;
  assign CarryOut  = carry_q;
  assign Zero      = zero_q;
  assign Negative  = neg_q;
  assign Overflow  = ovf_q;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (accept_s && is_mul_s),
    .a_i       (A),
    .b_i       (B),
    .busy_o    (mul_busy_s),
    .done_o    (mul_done_s),
    .product_o (mul_prod_s)
  );

  // Single-cycle result mux; unlisted opcodes fall back to ADD.
  always_comb begin
    sum_s     = {1'b0, A} + {1'b0, B};
    diff_s    = {1'b0, A} - {1'b0, B};
    ovf_add_s = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
    ovf_sub_s = (A[WIDTH-1] != B[WIDTH-1]) && (diff_s[WIDTH-1] != A[WIDTH-1]);
    res_d     = sum_s[WIDTH-1:0];
    carry_d   = sum_s[WIDTH];
    ovf_d     = ovf_add_s;
    case (ALU_Sel)
      OP_ADD: begin res_d = sum_s[WIDTH-1:0]; carry_d = sum_s[WIDTH]; ovf_d = ovf_add_s; end
      OP_SUB: begin res_d = diff_s[WIDTH-1:0]; carry_d = diff_s[WIDTH]; ovf_d = ovf_sub_s; end
      OP_SHL: begin res_d = {A[WIDTH-2:0], 1'b0}; carry_d = A[WIDTH-1]; ovf_d = 1'b0; end
      OP_SHR: begin res_d = {1'b0, A[WIDTH-1:1]}; carry_d = A[0]; ovf_d = 1'b0; end
      OP_ROL: begin res_d = {A[WIDTH-2:0], A[WIDTH-1]}; carry_d = A[WIDTH-1]; ovf_d = 1'b0; end
      OP_ROR: begin res_d = {A[0], A[WIDTH-1:1]}; carry_d = A[0]; ovf_d = 1'b0; end
      OP_AND: begin res_d = A & B; carry_d = 1'b0; ovf_d = 1'b0; end
      OP_OR:  begin res_d = A | B; carry_d = 1'b0; ovf_d = 1'b0; end
      OP_XOR: begin res_d = A ^ B; carry_d = 1'b0; ovf_d = 1'b0; end
      OP_GTU: begin res_d = {{(WIDTH-1){1'b0}}, (A > B)}; carry_d = 1'b0; ovf_d = 1'b0; end
      OP_EQ:  begin res_d = {{(WIDTH-1){1'b0}}, (A == B)}; carry_d = 1'b0; ovf_d = 1'b0; end
      OP_GTS: begin res_d = {{(WIDTH-1){1'b0}}, ($signed(A) > $signed(B))}; carry_d = 1'b0; ovf_d = 1'b0; end
      OP_MUL: begin res_d = {WIDTH{1'b0}}; carry_d = 1'b0; ovf_d = 1'b0; end
      OP_ASR: begin res_d = {A[WIDTH-1], A[WIDTH-1:1]}; carry_d = A[0]; ovf_d = 1'b0; end
      default: begin res_d = sum_s[WIDTH-1:0]; carry_d = sum_s[WIDTH]; ovf_d = ovf_add_s; end
    endcase
  end

  // Pipeline FSM and output register; the register only changes when empty or draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      res_q       <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s && is_mul_s) begin
            state_q     <= ST_MUL;
            out_valid_q <= 1'b0;
          end else if (accept_s) begin
            out_valid_q <= 1'b1;
            res_q       <= res_d;
            carry_q     <= carry_d;
            zero_q      <= (res_d == {WIDTH{1'b0}});
            neg_q       <= res_d[WIDTH-1];
            ovf_q       <= ovf_d;
          end else if (drain_s) begin
            out_valid_q <= 1'b0;
          end
        end
        ST_MUL: begin
          if (drain_s) begin
            out_valid_q <= 1'b0;
          end
          if (mul_done_s) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!out_valid_q || out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b1;
            res_q       <= mul_prod_s[WIDTH-1:0];
            carry_q     <= |mul_prod_s[2*WIDTH-1:WIDTH];
            zero_q      <= (mul_prod_s[WIDTH-1:0] == {WIDTH{1'b0}});
            neg_q       <= mul_prod_s[WIDTH-1];
            ovf_q       <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8) against an arithmetic reference model.
module tb_alu_pipe;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] A, B, ALU_Out;
  logic [3:0] ALU_Sel;
  logic       CarryOut, Zero, Negative, Overflow;

  int n_checks = 0;
  int n_pass   = 0;

  wire [11:0] obs_w = {ALU_Out, CarryOut, Zero, Negative, Overflow};

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .OPW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Out(ALU_Out), .CarryOut(CarryOut), .Zero(Zero), .Negative(Negative),
    .Overflow(Overflow)
  );

  // Reference: {result[7:0], C, Z, N, V} from plain integer arithmetic.
  function automatic logic [11:0] ref_alu(input int op, input int a, input int b);
    int sa, sb, r, c, v, t;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    c = 0; v = 0;
    case (op)
      1:  begin r = (a - b + 256) % 256; c = (a < b); v = ((sa - sb) > 127 || (sa - sb) < -128); end
      2:  begin r = (a * 2) % 256; c = a / 128; end
      3:  begin r = a / 2; c = a % 2; end
      4:  begin r = (a * 2 + a / 128) % 256; c = a / 128; end
      5:  begin r = a / 2 + (a % 2) * 128; c = a % 2; end
      6:  r = a & b;
      7:  r = a | b;
      8:  r = a ^ b;
      9:  r = (a > b) ? 1 : 0;
      10: r = (a == b) ? 1 : 0;
      11: r = (sa > sb) ? 1 : 0;
      12: begin t = a * b; r = t % 256; c = (t > 255); end
      13: begin r = a / 2 + (a & 128); c = a % 2; end
      default: begin t = a + b; r = t % 256; c = (t > 255); v = ((sa + sb) > 127 || (sa + sb) < -128); end
    endcase
    return {r[7:0], c[0], (r == 0), (r >= 128), v[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a bundle until it transfers (bounded); returns at edge+1 after the transfer.
  task automatic send(input int op, input int a, input int b, output bit ok);
    ALU_Sel = op[3:0]; A = a[7:0]; B = b[7:0]; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = 8'h00; B = 8'h00; ALU_Sel = 4'h0;
    #2;
    n_checks++;
    if ({out_valid, obs_w} !== 13'h0) $display("FAIL reset_outputs got %h exp 0", {out_valid, obs_w});
    else n_pass++;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_directed();
    int         ops[13] = '{0, 0, 1, 11, 9, 13, 4, 5, 10, 1, 15, 2, 3};
    int         as[13]  = '{'hFF, 'h7F, 'h03, 'hFF, 'hFF, 'h81, 'h81, 'h81, 'h5A, 'h80, 'h7F, 'hC3, 'hC3};
    int         bs[13]  = '{'h01, 'h01, 'h05, 'h01, 'h01, 'h00, 'h00, 'h00, 'h5A, 'h01, 'h01, 'h00, 'h00};
    logic [11:0] ex[13] = '{{8'h00, 4'b1100}, {8'h80, 4'b0011}, {8'hFE, 4'b1010},
                            {8'h00, 4'b0100}, {8'h01, 4'b0000}, {8'hC0, 4'b1010},
                            {8'h03, 4'b1000}, {8'hC0, 4'b1010}, {8'h01, 4'b0000},
                            {8'h7F, 4'b0001}, {8'h80, 4'b0011}, {8'h86, 4'b1010},
                            {8'h61, 4'b1000}};
    bit ok;
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      send(ops[i], as[i], bs[i], ok);
      n_checks++;
      if (!ok || out_valid !== 1'b1) $display("FAIL dir_valid[%0d] got ok=%b valid=%b exp 1", i, ok, out_valid);
      else n_pass++;
      n_checks++;
      if (obs_w !== ex[i]) $display("FAIL dir_result[%0d] got %h exp %h", i, obs_w, ex[i]);
      else n_pass++;
    end
  endtask

  task automatic test_mul();
    int  ma[10] = '{20, 0, 255, 'h55, 0, 0, 0, 0, 0, 0};
    int  mb[10] = '{13, 255, 255, 0, 0, 0, 0, 0, 0, 0};
    int  cycles, bad_ready;
    bit  ok;
    logic [11:0] ex;
    for (int i = 4; i < 10; i++) begin
      ma[i] = $urandom_range(0, 255); mb[i] = $urandom_range(0, 255);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ex = ref_alu(12, ma[i], mb[i]);
      send(12, ma[i], mb[i], ok);
      cycles = 0; bad_ready = 0;
      while (!out_valid && cycles < 40) begin
        if (in_ready !== 1'b0) bad_ready++;
        A = 8'($urandom); B = 8'($urandom); ALU_Sel = 4'($urandom); in_valid = 1'b1;
        tick();
        cycles++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (!ok || cycles !== 9) $display("FAIL mul_latency[%0d] got %0d exp 9", i, cycles);
      else n_pass++;
      n_checks++;
      if (bad_ready !== 0) $display("FAIL mul_in_ready[%0d] got %0d ready cycles exp 0", i, bad_ready);
      else n_pass++;
      n_checks++;
      if (obs_w !== ex) $display("FAIL mul_result[%0d] a=%0d b=%0d got %h exp %h", i, ma[i], mb[i], obs_w, ex);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int op, a, b;
    logic [11:0] ex;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 15);
      if (op == 12) op = 6;
      a = $urandom_range(0, 255); b = $urandom_range(0, 255);
      ex = ref_alu(op, a, b);
      ALU_Sel = op[3:0]; A = a[7:0]; B = b[7:0]; in_valid = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got %b exp 1", i, in_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || obs_w !== ex)
        $display("FAIL b2b_result[%0d] op=%0d got v=%b %h exp v=1 %h", i, op, out_valid, obs_w, ex);
      else n_pass++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random_stall();
    int op, a, b, cycles, stall;
    bit ok;
    logic [11:0] ex;
    for (int i = 0; i < 25; i++) begin
      out_ready = 1'b1;
      op = $urandom_range(0, 15); a = $urandom_range(0, 255); b = $urandom_range(0, 255);
      ex = ref_alu(op, a, b);
      send(op, a, b, ok);
      cycles = 0;
      while (!out_valid && cycles < 40) begin
        tick();
        cycles++;
      end
      n_checks++;
      if (!ok || out_valid !== 1'b1 || obs_w !== ex)
        $display("FAIL rand_result[%0d] op=%0d got v=%b %h exp v=1 %h", i, op, out_valid, obs_w, ex);
      else n_pass++;
      stall = $urandom_range(1, 3);
      out_ready = 1'b0;
      for (int s = 0; s < stall; s++) tick();
      n_checks++;
      if (out_valid !== 1'b1 || obs_w !== ex)
        $display("FAIL rand_hold[%0d] got v=%b %h exp v=1 %h", i, out_valid, obs_w, ex);
      else n_pass++;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_backpressure();
    int a, b, xa, xb, bad;
    bit ok;
    logic [11:0] ex_and, ex_xor;
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL bp_drain got %b exp 0", out_valid);
    else n_pass++;
    a = $urandom_range(0, 255); b = $urandom_range(0, 255);
    xa = $urandom_range(0, 255); xb = $urandom_range(0, 255);
    ex_and = ref_alu(6, a, b); ex_xor = ref_alu(8, xa, xb);
    out_ready = 1'b0;
    send(6, a, b, ok);
    ALU_Sel = 4'b1000; A = xa[7:0]; B = xb[7:0]; in_valid = 1'b1;
    #1;
    bad = ok ? 0 : 1;
    for (int i = 0; i < 5; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs_w !== ex_and) bad++;
      tick();
    end
    n_checks++;
    if (bad !== 0) $display("FAIL bp_hold got %0d bad cycles exp 0 (last %h exp %h)", bad, obs_w, ex_and);
    else n_pass++;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", in_ready);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || obs_w !== ex_xor) $display("FAIL bp_xor got v=%b %h exp v=1 %h", out_valid, obs_w, ex_xor);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mul();
    bit ok1, ok2;
    int stale;
    out_ready = 1'b1;
    send(0, 'h7F, 'h01, ok1);
    send(12, 20, 13, ok2);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (!ok1 || !ok2 || {out_valid, obs_w} !== 13'h0)
      $display("FAIL midmul_reset got %h exp 0", {out_valid, obs_w});
    else n_pass++;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL midmul_ready got %b exp 1", in_ready);
    else n_pass++;
    stale = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid !== 1'b0) stale++;
      tick();
    end
    n_checks++;
    if (stale !== 0) $display("FAIL midmul_stale got %0d valid cycles exp 0", stale);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_back_to_back();
    test_random_stall();
    test_backpressure();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
